// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width and the divider FSM state encoding.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; the caller registers the new partial remainder.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dsr_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // One extra bit above the W+1 partial remainder so the trial sign is never lost.
  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {2'b00, dsr_i};
  assign q_o     = ~trial[W+1];
  assign rem_o   = q_o ? trial[W:0] : shifted[W:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// magnitudes divided unsigned with a sign fix-up cycle, start/busy/done handshake.
module seq_divider
  import mips_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W:0]    rem_q;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dsr_q;
  logic          q_neg_q, r_neg_q, dbz_q;
  logic [W-1:0]  quo_q, rmd_q;
  logic          dbz_out_q;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    step_rem;
  logic          step_q;

  assign a_neg = is_signed & dividend[W-1];
  assign b_neg = is_signed & divisor[W-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  // dvd_q doubles as the quotient: dividend bits shift out the top as quotient bits enter the bottom.
  div_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[W-1]),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= a_mag;
            dsr_q     <= b_mag;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            dbz_q     <= (divisor == '0);
            dbz_out_q <= 1'b0;
          end
        end
        RUN: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[W-2:0], step_q};
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          // With a zero divisor the remainder path already yields the original dividend after sign fix-up.
          quo_q     <= dbz_q ? '1 : (q_neg_q ? -dvd_q : dvd_q);
          rmd_q     <= r_neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
          dbz_out_q <= dbz_q;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_out_q;

endmodule
